// File: rtl/qspi_line_arb_if.sv
// Signal bundle between the I/D cache line ports, the line arbiter and the QSPI line engine.
// The arbiter uses the slave modport; cache clients and the engine sit on the master side.
interface qspi_line_arb_if #(
   parameter int LINE_LENGTH = 4,
   parameter int PA          = 24
);
   localparam int LW = $clog2(LINE_LENGTH);

   logic                     ic_req;
   logic                     ic_mem;
   logic [PA-LW-1:0]         ic_paddr;
   logic                     ic_ack;

   logic                     dc_req;
   logic                     dc_write;
   logic                     dc_mem;
   logic [PA-LW-1:0]         dc_paddr;
   logic [8*LINE_LENGTH-1:0] dc_wdata;
   logic                     dc_ack;

   logic [8*LINE_LENGTH-1:0] rdata;

   logic                     qspi_ready;
   logic [1:0]               cs;
   logic                     q_req;
   logic                     q_i_d;
   logic                     q_mem;
   logic                     q_write;
   logic [PA-LW-1:0]         q_paddr;
   logic [3:0]               q_dwrite;
   logic                     q_rstrobe_d;
   logic                     q_wstrobe_i;
   logic                     q_wstrobe_d;
   logic [3:0]               q_din;

   modport slave (
      input  ic_req, ic_mem, ic_paddr,
      output ic_ack,
      input  dc_req, dc_write, dc_mem, dc_paddr, dc_wdata,
      output dc_ack, rdata,
      input  qspi_ready, cs,
      output q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
      input  q_rstrobe_d, q_wstrobe_i, q_wstrobe_d, q_din
   );

   modport master (
      output ic_req, ic_mem, ic_paddr,
      input  ic_ack,
      output dc_req, dc_write, dc_mem, dc_paddr, dc_wdata,
      input  dc_ack, rdata,
      output qspi_ready, cs,
      input  q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
      output q_rstrobe_d, q_wstrobe_i, q_wstrobe_d, q_din
   );
endinterface

// File: rtl/qspi_line_arb.sv
// Round-robin arbiter between I-cache and D-cache line requests feeding the QSPI line engine.
// Streams write nibbles out of a line buffer and assembles read nibbles into rdata.
module qspi_line_arb #(
   parameter int LINE_LENGTH = 4,
   parameter int PA          = 24
) (
   input  logic           clk,
   input  logic           reset_n,
   qspi_line_arb_if.slave bus
);
   localparam int LW = $clog2(LINE_LENGTH);
   localparam int AW = PA - LW;
   localparam int LB = 8 * LINE_LENGTH;
   localparam int CW = LW + 2;
   localparam logic [CW-1:0] NN = CW'(2 * LINE_LENGTH);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

   state_t          state_q, state_d;
   logic            last_i_q, last_i_d;
   logic            q_req_q, q_req_d;
   logic            i_d_q, i_d_d;
   logic            mem_q, mem_d;
   logic            write_q, write_d;
   logic [AW-1:0]   paddr_q, paddr_d;
   logic [LB-1:0]   wbuf_q, wbuf_d;
   logic [LB-1:0]   rdata_q, rdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [LW+2:0]   nib_lo;
   logic            grant_i;
   logic            rd_strobe;

   // Nibble n lives in byte n/2; the even nibble is the high half of that byte.
   assign nib_lo    = {cnt_q[LW:1], ~cnt_q[0], 2'b00};
   assign grant_i   = bus.ic_req & (~bus.dc_req | ~last_i_q);
   assign rd_strobe = i_d_q ? bus.q_wstrobe_i : bus.q_wstrobe_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_i_q <= 1'b0;
         q_req_q  <= 1'b0;
         i_d_q    <= 1'b0;
         mem_q    <= 1'b0;
         write_q  <= 1'b0;
         paddr_q  <= '0;
         wbuf_q   <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_i_q <= last_i_d;
         q_req_q  <= q_req_d;
         i_d_q    <= i_d_d;
         mem_q    <= mem_d;
         write_q  <= write_d;
         paddr_q  <= paddr_d;
         wbuf_q   <= wbuf_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_i_d = last_i_q;
      q_req_d  = q_req_q;
      i_d_d    = i_d_q;
      mem_d    = mem_q;
      write_d  = write_q;
      paddr_d  = paddr_q;
      wbuf_d   = wbuf_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.qspi_ready && (bus.ic_req || bus.dc_req)) begin
               state_d  = REQ;
               q_req_d  = 1'b1;
               last_i_d = grant_i;
               i_d_d    = grant_i;
               cnt_d    = '0;
               if (grant_i) begin
                  mem_d   = bus.ic_mem;
                  write_d = 1'b0;
                  paddr_d = bus.ic_paddr;
               end else begin
                  mem_d   = bus.dc_mem;
                  write_d = bus.dc_write;
                  paddr_d = bus.dc_paddr;
                  if (bus.dc_write) begin
                     wbuf_d = bus.dc_wdata;
                  end
               end
            end
         end
         REQ: begin
            if (!bus.cs[mem_q]) begin
               q_req_d = 1'b0;
               state_d = XFER;
            end
         end
         XFER: begin
            // Once the full line has moved, further strobes are ignored until cs releases.
            if (cnt_q != NN) begin
               if (write_q) begin
                  if (bus.q_rstrobe_d) begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (rd_strobe) begin
                  rdata_d[nib_lo +: 4] = bus.q_din;
                  cnt_d                = cnt_q + CW'(1);
               end
            end else if (bus.cs == 2'b11) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.q_req    = q_req_q;
   assign bus.q_i_d    = i_d_q;
   assign bus.q_mem    = mem_q;
   assign bus.q_write  = write_q;
   assign bus.q_paddr  = paddr_q;
   assign bus.q_dwrite = write_q ? wbuf_q[nib_lo +: 4] : 4'h0;
   assign bus.ic_ack   = (state_q == DONE) & i_d_q;
   assign bus.dc_ack   = (state_q == DONE) & ~i_d_q;
   assign bus.rdata    = rdata_q;
endmodule
